// File: rtl/cpu_defs.sv
// Shared definitions for the branch prediction unit.
// Branch type codes, correction FSM states and BTB entry layout.
package cpu_defs;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BRA  = 3'd1;
  localparam logic [2:0] BR_J    = 3'd2;
  localparam logic [2:0] BR_CALL = 3'd3;
  localparam logic [2:0] BR_RET  = 3'd4;

  typedef enum logic {
    IDLE,
    CORRECTION
  } state_e;

  localparam int BTB_TAG_W = 20;
  localparam int BTB_CNT_W = 2;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          target;
    logic [BTB_CNT_W-1:0] cnt;
  } btb_entry_t;

  function automatic logic [31:0] pc_plus8(
    input logic [31:0] pc
  );
    return pc + 32'd8;
  endfunction

endpackage

// File: rtl/ras_ckpt.sv
// Circular return-address stack with pointer checkpoint/restore.
// ckpt = {count != 0, ptr}; ptr is the next free slot.
module ras_ckpt #(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   push_data,
  input  logic          restore,
  input  logic [PW:0]   restore_ptr,
  output logic [31:0]   top,
  output logic          top_valid,
  output logic [PW:0]   ckpt
);

  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [31:0]   r_buf [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [PW:0]   r_cnt;
  logic [PW-1:0] w_top_idx;

  assign w_top_idx = r_ptr - PW'(1);
  assign top       = r_buf[w_top_idx];
  assign top_valid = (r_cnt != '0);
  assign ckpt      = {top_valid, r_ptr};

  // Pointer and occupancy; a restore wins over push/pop.
  // A restored non-empty stack is treated as full so the
  // older entries still left in the buffer stay poppable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (restore) begin
      r_ptr <= restore_ptr[PW-1:0];
      r_cnt <= restore_ptr[PW] ? FULL : '0;
    end else if (push) begin
      r_ptr <= r_ptr + PW'(1);
      if (r_cnt != FULL) r_cnt <= r_cnt + (PW+1)'(1);
    end else if (pop && top_valid) begin
      r_ptr <= r_ptr - PW'(1);
      r_cnt <= r_cnt - (PW+1)'(1);
    end
  end

  // Return address storage; wrong-path pushes are dropped.
  always_ff @(posedge clk) begin
    if (push && !restore) r_buf[r_ptr] <= push_data;
  end

endmodule

// File: rtl/bpu_param.sv
// Branch prediction unit: direct-mapped BTB, RAS and a
// correction FSM that redirects fetch on mispredicts.
module bpu_param
  import cpu_defs::*;
#(
  parameter  int IDX_W     = 8,
  parameter  int TAG_W     = BTB_TAG_W,
  parameter  int CNT_W     = BTB_CNT_W,
  parameter  int RAS_DEPTH = 8,
  parameter  int BYPASS    = 1,
  localparam int RAS_PW    = $clog2(RAS_DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush_i,
  input  logic              lookup_valid,
  input  logic [31:0]       lookup_pc,
  input  logic [2:0]        lookup_br_type,
  output logic              pred_valid,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  output logic [CNT_W-1:0]  pred_cnt,
  output logic [RAS_PW:0]   pred_ras_ptr,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic [2:0]        upd_br_type,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_mispredict,
  input  logic [CNT_W-1:0]  upd_cnt,
  input  logic [RAS_PW:0]   upd_ras_ptr,
  input  logic              correct_finish,
  output logic              redirect,
  output logic              is_correction,
  output logic [31:0]       correct_target
);

  localparam int ENTRIES = 2**IDX_W;
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] WT  = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] WNT = {1'b0, {(CNT_W-1){1'b1}}};

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [31:0]        r_tgt [ENTRIES];
  logic [CNT_W-1:0]   r_cnt [ENTRIES];
  state_e             r_state;
  logic [31:0]        r_ctgt;

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_we;
  logic             w_byp;
  logic [CNT_W-1:0] w_new_cnt;
  entry_t           w_rd;
  entry_t           w_wr;
  entry_t           w_ent;
  logic             w_hit;
  logic [31:0]      w_pc8;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_ras_top;
  logic             w_ras_vld;
  state_e           w_nstate;
  logic [31:0]      w_nctgt;

  assign w_lk_idx = lookup_pc[IDX_W+1:2];
  assign w_lk_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_up_idx = upd_pc[IDX_W+1:2];
  assign w_up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_we     = upd_valid && (upd_br_type != BR_NONE);
  assign w_byp    = (BYPASS != 0) && w_we &&
                    (w_up_idx == w_lk_idx);

  // Saturating counter step, or weak reset on mispredict.
  always_comb begin
    w_new_cnt = upd_cnt;
    if (upd_mispredict) begin
      w_new_cnt = upd_taken ? WT : WNT;
    end else if (upd_taken) begin
      if (upd_cnt != CMAX) w_new_cnt = upd_cnt + CNT_W'(1);
    end else begin
      if (upd_cnt != '0) w_new_cnt = upd_cnt - CNT_W'(1);
    end
  end

  assign w_wr  = '{1'b1, w_up_tag, upd_target, w_new_cnt};
  assign w_rd  = '{r_valid[w_lk_idx], r_tag[w_lk_idx],
                   r_tgt[w_lk_idx], r_cnt[w_lk_idx]};
  assign w_ent = w_byp ? w_wr : w_rd;
  assign w_hit = w_ent.valid && (w_ent.tag == w_lk_tag);
  assign w_pc8 = pc_plus8(lookup_pc);

  assign pred_valid = lookup_valid &&
                      (lookup_br_type != BR_NONE) &&
                      (r_state == IDLE);
  assign pred_hit   = w_hit;
  assign pred_cnt   = w_ent.cnt;

  // Direction and next fetch PC by branch type.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = w_pc8;
    unique case (1'b1)
      lookup_br_type == BR_RET: begin
        if (w_ras_vld) begin
          pred_taken  = 1'b1;
          pred_target = w_ras_top;
        end
      end
      lookup_br_type == BR_BRA: begin
        if (w_hit && w_ent.cnt[CNT_W-1]) begin
          pred_taken  = 1'b1;
          pred_target = w_ent.target;
        end
      end
      lookup_br_type == BR_J,
      lookup_br_type == BR_CALL: begin
        if (w_hit) begin
          pred_taken  = 1'b1;
          pred_target = w_ent.target;
        end
      end
      default: ;
    endcase
  end

  assign w_push   = pred_valid && (lookup_br_type == BR_CALL);
  assign w_pop    = pred_valid && (lookup_br_type == BR_RET);
  assign redirect = upd_valid && upd_mispredict &&
                    (r_state == IDLE);

  ras_ckpt #(
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rst_n      (resetn),
    .push       (w_push),
    .pop        (w_pop),
    .push_data  (w_pc8),
    .restore    (redirect),
    .restore_ptr(upd_ras_ptr),
    .top        (w_ras_top),
    .top_valid  (w_ras_vld),
    .ckpt       (pred_ras_ptr)
  );

  // Entry valid bits, cleared by reset only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= '0;
    end else if (w_we) begin
      r_valid[w_up_idx] <= 1'b1;
    end
  end

  // Entry payload storage.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_tag[w_up_idx] <= w_up_tag;
      r_tgt[w_up_idx] <= upd_target;
      r_cnt[w_up_idx] <= w_new_cnt;
    end
  end

  // Correction FSM next state and redirect target; flush wins.
  always_comb begin
    w_nstate = r_state;
    w_nctgt  = r_ctgt;
    unique case (r_state)
      IDLE: begin
        if (redirect) begin
          w_nstate = CORRECTION;
          w_nctgt  = upd_taken ? upd_target
                               : pc_plus8(upd_pc);
        end
      end
      CORRECTION: begin
        if (correct_finish) w_nstate = IDLE;
      end
    endcase
    if (flush_i) begin
      w_nstate = IDLE;
      w_nctgt  = '0;
    end
  end

  // Correction FSM state and target registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_ctgt  <= '0;
    end else begin
      r_state <= w_nstate;
      r_ctgt  <= w_nctgt;
    end
  end

  assign is_correction  = (r_state == CORRECTION);
  assign correct_target = r_ctgt;

endmodule

// File: tb/tb_bpu_param.sv
// Directed bench for bpu_param (default parameters).
// Inputs change 1ns after posedge; outputs are sampled before the next edge.
module tb_bpu_param;

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_BRA  = 3'd1;
  localparam logic [2:0] T_J    = 3'd2;
  localparam logic [2:0] T_CALL = 3'd3;
  localparam logic [2:0] T_RET  = 3'd4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush_i;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic [2:0]  lookup_br_type;
  logic        pred_valid;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [1:0]  pred_cnt;
  logic [3:0]  pred_ras_ptr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [2:0]  upd_br_type;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [1:0]  upd_cnt;
  logic [3:0]  upd_ras_ptr;
  logic        correct_finish;
  logic        redirect;
  logic        is_correction;
  logic [31:0] correct_target;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bpu_param #(
    .IDX_W(8), .TAG_W(20), .CNT_W(2),
    .RAS_DEPTH(8), .BYPASS(1)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .flush_i       (flush_i),
    .lookup_valid  (lookup_valid),
    .lookup_pc     (lookup_pc),
    .lookup_br_type(lookup_br_type),
    .pred_valid    (pred_valid),
    .pred_hit      (pred_hit),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .pred_cnt      (pred_cnt),
    .pred_ras_ptr  (pred_ras_ptr),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_br_type   (upd_br_type),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .upd_mispredict(upd_mispredict),
    .upd_cnt       (upd_cnt),
    .upd_ras_ptr   (upd_ras_ptr),
    .correct_finish(correct_finish),
    .redirect      (redirect),
    .is_correction (is_correction),
    .correct_target(correct_target)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    flush_i        = 1'b0;
    lookup_valid   = 1'b0;
    lookup_pc      = '0;
    lookup_br_type = T_NONE;
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_br_type    = T_NONE;
    upd_taken      = 1'b0;
    upd_target     = '0;
    upd_mispredict = 1'b0;
    upd_cnt        = '0;
    upd_ras_ptr    = '0;
    correct_finish = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc,
                        input logic [2:0] t);
    lookup_valid   = 1'b1;
    lookup_pc      = pc;
    lookup_br_type = t;
  endtask

  task automatic upd(input logic [31:0] pc,
                     input logic [2:0] t,
                     input logic tk,
                     input logic [31:0] tg,
                     input logic mis,
                     input logic [1:0] c);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_br_type    = t;
    upd_taken      = tk;
    upd_target     = tg;
    upd_mispredict = mis;
    upd_cnt        = c;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clr();
    step();
    step();
    checks++;
    if (is_correction !== 1'b0) begin
      errors++;
      $display("FAIL rst_corr got %b exp 0", is_correction);
    end
    checks++;
    if (correct_target !== 32'h0) begin
      errors++;
      $display("FAIL rst_ctgt got %h exp 0", correct_target);
    end
    checks++;
    if (pred_ras_ptr !== 4'h0) begin
      errors++;
      $display("FAIL rst_ras got %h exp 0", pred_ras_ptr);
    end
    resetn = 1'b1;
    lookup(32'h0040_0010, T_BRA);
    #1;
    checks++;
    if (pred_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pv got %b exp 1", pred_valid);
    end
    checks++;
    if (pred_hit !== 1'b0 || pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL rst_hit got %b%b exp 00",
               pred_hit, pred_taken);
    end
    checks++;
    if (pred_target !== 32'h0040_0018) begin
      errors++;
      $display("FAIL rst_tgt got %h exp 00400018",
               pred_target);
    end
  endtask

  task automatic test_mispredict();
    step();
    clr();
    upd(32'h0040_0010, T_BRA, 1'b1, 32'h0040_0100, 1'b1, 2'd1);
    #1;
    checks++;
    if (redirect !== 1'b1) begin
      errors++;
      $display("FAIL mis_redir got %b exp 1", redirect);
    end
    step();
    clr();
    #1;
    checks++;
    if (is_correction !== 1'b1) begin
      errors++;
      $display("FAIL mis_corr got %b exp 1", is_correction);
    end
    checks++;
    if (correct_target !== 32'h0040_0100) begin
      errors++;
      $display("FAIL mis_ctgt got %h exp 00400100",
               correct_target);
    end
    correct_finish = 1'b1;
    step();
    clr();
    checks++;
    if (is_correction !== 1'b0) begin
      errors++;
      $display("FAIL mis_fin got %b exp 0", is_correction);
    end
    lookup(32'h0040_0010, T_BRA);
    #1;
    checks++;
    if (pred_hit !== 1'b1 || pred_cnt !== 2'd2 ||
        pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL mis_look got hit %b cnt %0d tk %b exp 1 2 1",
               pred_hit, pred_cnt, pred_taken);
    end
    checks++;
    if (pred_target !== 32'h0040_0100) begin
      errors++;
      $display("FAIL mis_ltgt got %h exp 00400100",
               pred_target);
    end
  endtask

  task automatic test_counter();
    logic [1:0]  c_in  [5] = '{2'd2, 2'd3, 2'd3, 2'd0, 2'd3};
    logic        c_tk  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        c_mis [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]  c_exp [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1};
    logic        e_tk  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] e_tg  [5] = '{32'h0040_0100, 32'h0040_0100,
                              32'h0040_0100, 32'h0040_0018,
                              32'h0040_0018};
    for (int i = 0; i < 5; i++) begin
      step();
      clr();
      upd(32'h0040_0010, T_BRA, c_tk[i], 32'h0040_0100,
          c_mis[i], c_in[i]);
      step();
      clr();
      lookup(32'h0040_0010, T_BRA);
      #1;
      checks++;
      if (pred_cnt !== c_exp[i] || pred_taken !== e_tk[i] ||
          pred_target !== e_tg[i]) begin
        errors++;
        $display("FAIL cnt_%0d got %0d %b %h exp %0d %b %h", i,
                 pred_cnt, pred_taken, pred_target,
                 c_exp[i], e_tk[i], e_tg[i]);
      end
    end
    checks++;
    if (is_correction !== 1'b1 ||
        correct_target !== 32'h0040_0018) begin
      errors++;
      $display("FAIL cnt_ctgt got %b %h exp 1 00400018",
               is_correction, correct_target);
    end
    correct_finish = 1'b1;
    step();
    clr();
  endtask

  task automatic test_ras();
    for (int i = 0; i < 9; i++) begin
      lookup(32'h1000 + 32'(16 * i), T_CALL);
      #1;
      if (i == 0) begin
        checks++;
        if (pred_ras_ptr !== 4'h0) begin
          errors++;
          $display("FAIL ras_ck0 got %h exp 0", pred_ras_ptr);
        end
      end
      step();
    end
    for (int k = 0; k < 8; k++) begin
      lookup(32'h2000, T_RET);
      #1;
      if (k == 0) begin
        checks++;
        if (pred_ras_ptr !== 4'h9) begin
          errors++;
          $display("FAIL ras_ck9 got %h exp 9", pred_ras_ptr);
        end
      end
      checks++;
      if (pred_taken !== 1'b1 ||
          pred_target !== 32'h1088 - 32'(16 * k)) begin
        errors++;
        $display("FAIL ras_pop%0d got %b %h exp 1 %h", k,
                 pred_taken, pred_target, 32'h1088 - 32'(16 * k));
      end
      step();
    end
    lookup(32'h2000, T_RET);
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h2008 ||
        pred_ras_ptr !== 4'h1) begin
      errors++;
      $display("FAIL ras_empty got %b %h %h exp 0 00002008 1",
               pred_taken, pred_target, pred_ras_ptr);
    end
    step();
    lookup(32'h3000, T_CALL);
    step();
    lookup(32'h3100, T_CALL);
    step();
    lookup(32'h3200, T_CALL);
    upd(32'h5000, T_BRA, 1'b0, 32'h5100, 1'b1, 2'd0);
    upd_ras_ptr = 4'b1010;
    #1;
    checks++;
    if (redirect !== 1'b1) begin
      errors++;
      $display("FAIL ras_redir got %b exp 1", redirect);
    end
    step();
    clr();
    checks++;
    if (correct_target !== 32'h5008) begin
      errors++;
      $display("FAIL ras_ctgt got %h exp 00005008",
               correct_target);
    end
    correct_finish = 1'b1;
    step();
    clr();
    lookup(32'h2000, T_RET);
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h3008 ||
        pred_ras_ptr !== 4'hA) begin
      errors++;
      $display("FAIL ras_rest got %b %h %h exp 1 00003008 a",
               pred_taken, pred_target, pred_ras_ptr);
    end
    step();
    clr();
  endtask

  task automatic test_correction();
    upd(32'h0040_0200, T_J, 1'b1, 32'h0040_0800, 1'b1, 2'd0);
    #1;
    checks++;
    if (redirect !== 1'b1) begin
      errors++;
      $display("FAIL cor_r1 got %b exp 1", redirect);
    end
    step();
    clr();
    upd(32'h0040_0300, T_J, 1'b1, 32'h0040_9000, 1'b1, 2'd0);
    #1;
    checks++;
    if (redirect !== 1'b0) begin
      errors++;
      $display("FAIL cor_r2 got %b exp 0", redirect);
    end
    step();
    clr();
    checks++;
    if (is_correction !== 1'b1 ||
        correct_target !== 32'h0040_0800) begin
      errors++;
      $display("FAIL cor_hold got %b %h exp 1 00400800",
               is_correction, correct_target);
    end
    lookup(32'h0040_0300, T_J);
    #1;
    checks++;
    if (pred_hit !== 1'b1 || pred_valid !== 1'b0 ||
        pred_target !== 32'h0040_9000) begin
      errors++;
      $display("FAIL cor_btb got %b %b %h exp 1 0 00409000",
               pred_hit, pred_valid, pred_target);
    end
    clr();
    correct_finish = 1'b1;
    step();
    clr();
    checks++;
    if (is_correction !== 1'b0 ||
        correct_target !== 32'h0040_0800) begin
      errors++;
      $display("FAIL cor_fin got %b %h exp 0 00400800",
               is_correction, correct_target);
    end
    upd(32'h0040_0200, T_J, 1'b1, 32'h0040_0900, 1'b1, 2'd0);
    flush_i = 1'b1;
    step();
    clr();
    checks++;
    if (is_correction !== 1'b0 || correct_target !== 32'h0) begin
      errors++;
      $display("FAIL cor_flush got %b %h exp 0 0",
               is_correction, correct_target);
    end
  endtask

  task automatic test_bypass();
    upd(32'h0040_0400, T_BRA, 1'b1, 32'h0040_0A00, 1'b0, 2'd1);
    lookup(32'h0040_0400, T_BRA);
    #1;
    checks++;
    if (pred_hit !== 1'b1 || pred_target !== 32'h0040_0A00 ||
        pred_cnt !== 2'd2 || pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL byp_same got %b %h %0d %b exp 1 00400a00 2 1",
               pred_hit, pred_target, pred_cnt, pred_taken);
    end
    lookup(32'h0080_0400, T_BRA);
    #1;
    checks++;
    if (pred_hit !== 1'b0 || pred_target !== 32'h0080_0408) begin
      errors++;
      $display("FAIL byp_tag got %b %h exp 0 00800408",
               pred_hit, pred_target);
    end
    step();
    clr();
    lookup(32'h0040_0400, T_BRA);
    #1;
    checks++;
    if (pred_hit !== 1'b1 || pred_target !== 32'h0040_0A00) begin
      errors++;
      $display("FAIL byp_store got %b %h exp 1 00400a00",
               pred_hit, pred_target);
    end
    clr();
  endtask

  task automatic test_pc_wrap();
    lookup(32'hFFFF_FFFC, T_NONE);
    #1;
    checks++;
    if (pred_target !== 32'h4 || pred_valid !== 1'b0 ||
        pred_taken !== 1'b0) begin
      errors++;
      $display("FAIL wrap got %h %b %b exp 00000004 0 0",
               pred_target, pred_valid, pred_taken);
    end
    clr();
  endtask

  task automatic test_reset_mid();
    step();
    upd(32'h0040_0010, T_BRA, 1'b1, 32'h0040_0100, 1'b1, 2'd1);
    step();
    clr();
    lookup(32'h0040_0010, T_BRA);
    #1;
    checks++;
    if (is_correction !== 1'b1 || pred_hit !== 1'b1) begin
      errors++;
      $display("FAIL rm_pre got %b %b exp 1 1",
               is_correction, pred_hit);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (is_correction !== 1'b0 || pred_hit !== 1'b0 ||
        correct_target !== 32'h0) begin
      errors++;
      $display("FAIL rm_async got %b %b %h exp 0 0 0",
               is_correction, pred_hit, correct_target);
    end
    step();
    resetn = 1'b1;
    clr();
  endtask

  initial begin
    clr();
    test_reset();
    test_mispredict();
    test_counter();
    test_ras();
    test_correction();
    test_bypass();
    test_pc_wrap();
    test_reset_mid();
    step();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/bpu_param.md
Name: bpu_param

Overview:
- Parametrised next-generation branch prediction unit for the IF/ID stage.
- Holds a direct-mapped BTB with per-entry valid bits and CNT_W-bit saturating counters, plus a circular return-address stack (RAS) that checkpoints its pointer on every lookup and restores it on misprediction.
- A two-state correction FSM issues redirects.
- Lookups arrive from the decode-stage PC; updates arrive from the execute-stage branch resolution.

Parameters:
- IDX_W, 8: BTB index width; ENTRIES = 2**IDX_W.
- TAG_W, 20: stored tag width; must satisfy IDX_W+2+TAG_W <= 32.
- CNT_W, 2: saturating counter width, 2..4.
- RAS_DEPTH, 8: RAS entries, power of two; RAS_PW = log2(RAS_DEPTH).
- BYPASS, 1: 1 forwards a same-cycle update to a lookup of the same index.

Ports:
- clk in 1: clock.
- resetn in 1: reset, asynchronous, active-low.
- flush_i in 1: exception/eret/tlb flush.
- lookup_valid in 1: decode PC valid.
- lookup_pc in 32: decode PC.
- lookup_br_type in 3: 0 none, 1 BRA, 2 J, 3 CALL, 4 RET.
- pred_valid out 1: prediction usable.
- pred_hit out 1: BTB hit.
- pred_taken out 1: predicted direction.
- pred_target out 32: predicted next fetch PC.
- pred_cnt out CNT_W: counter read, carried down the pipe.
- pred_ras_ptr out RAS_PW+1: RAS checkpoint, {count-nonzero, ptr}, carried down the pipe.
- upd_valid in 1: resolved branch.
- upd_pc in 32: branch PC.
- upd_br_type in 3: branch type.
- upd_taken in 1: actual direction.
- upd_target in 32: actual target.
- upd_mispredict in 1: prediction was wrong.
- upd_cnt in CNT_W: counter carried with the branch.
- upd_ras_ptr in RAS_PW+1: checkpoint carried with the branch.
- correct_finish in 1: fetch has consumed the redirect.
- redirect out 1: pulse, flush the younger pipeline.
- is_correction out 1: FSM is in CORRECTION.
- correct_target out 32: registered redirect PC.

Behaviour:
- Reset:
  - all valid bits 0, RAS ptr 0 and count 0, FSM IDLE, correct_target 0.
  - Combinational outputs follow from this reset state.
- Field split: index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Lookup timing: latency 0, combinational from lookup_pc.
  - hit = valid[index] && tag match.
  - pred_valid = lookup_valid && lookup_br_type != 0 && state == IDLE.
- Prediction by branch type:
  - Miss or type 0: target = pc+8, not taken.
  - BRA: taken iff cnt[CNT_W-1]; target is the entry target, else pc+8.
  - J, CALL: taken, entry target.
  - RET: RAS non-empty gives taken with target = RAS top, even on a BTB miss; empty gives not taken, pc+8.
- RAS, updated only when pred_valid:
  - CALL pushes lookup_pc+8.
  - RET pops.
  - Overflow overwrites the oldest entry; the count saturates at RAS_DEPTH.
  - Pop on empty is a no-op.
  - pred_ras_ptr is the pre-operation checkpoint.
- BTB write: on upd_valid && upd_br_type != 0, write valid, tag, upd_target and the new counter at upd_pc's index.
- Counter update rules:
  - Correct prediction: saturating +1 if taken, -1 if not; no wrap at 0 or 2**CNT_W-1.
  - Mispredict: weak-taken = 2**(CNT_W-1) if taken, weak-not-taken = 2**(CNT_W-1)-1 if not.
- Same-cycle write/read:
  - BYPASS=1 and same index: the lookup sees the new entry.
  - BYPASS=0: the lookup sees the old entry.
- Mispredict with state == IDLE, all in the same cycle:
  - redirect = 1 combinationally.
  - RAS pointer/count restored from upd_ras_ptr; the restore overrides any same-cycle push/pop.
  - State goes to CORRECTION; correct_target <= (upd_taken ? upd_target : upd_pc+8).
- FSM transitions:
  - CORRECTION -> IDLE on correct_finish.
  - Mispredicts in CORRECTION still write the BTB but produce no redirect and no restore.
- flush_i: highest priority; state goes to IDLE and correct_target to 0. BTB and RAS contents are untouched.
- Width rules: all PC arithmetic is 32-bit modulo 2**32 (0xFFFFFFFC+8 = 0x4).

Decomposition:
- Shared package (cpu_defs): branch-type constants, FSM state enum (IDLE, CORRECTION), and a btb_entry_t struct {valid, tag, target, cnt} parametrised via localparams.
- One sub-module, ras_ckpt:
  - ports: push, pop, push_data, restore, restore_ptr, top, top_valid, ckpt.
  - internal state: circular buffer with ptr and count.

Test Plan:
- After reset, lookup pc 0x00400010 BRA -> pred_hit 0, pred_taken 0, pred_target 0x00400018.
- Update pc 0x00400010 BRA taken, target 0x00400100, mispredict -> redirect 1 the same cycle. Next cycle is_correction 1, correct_target 0x00400100. The following lookup gives hit, cnt=2, taken.
- Correct BRA updates: cnt 2->3, then 3 stays 3 on taken. A not-taken correct update gives 3->2. A not-taken mispredict at cnt 3 writes 1.
- Nine CALLs (RAS_DEPTH 8) from 0x1000 step 0x10 pop back correctly: eight RETs return 0x1088 down to 0x1018. The ninth RET is empty: not taken, pc+8.
- In CORRECTION, a second mispredict gives redirect 0 and correct_target unchanged. Then correct_finish gives IDLE. A flush_i asserted in the same cycle as a mispredict gives IDLE and correct_target 0.
- BYPASS=1: same-index update and lookup in one cycle -> the lookup sees the new target. resetn dropped mid-CORRECTION -> immediately is_correction 0 and pred_hit 0.
